// File: rtl/cc_enc_parm_if.sv
// Stream bundle between the randomizer side and the convolutional encoder.
// master drives the input word stream and reload; slave is the encoder.
interface cc_enc_parm_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   in_bits;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic                reload;
  logic [2*DATA_W-1:0] out_bits;
  logic                out_valid;
  logic                out_last;

  modport master (
    output in_bits, in_valid, in_last, reload,
    input  in_ready, out_bits, out_valid, out_last
  );

  modport slave (
    input  in_bits, in_valid, in_last, reload,
    output in_ready, out_bits, out_valid, out_last
  );
endinterface

// File: rtl/cc_enc_parm.sv
// Rate-1/2, K=7 convolutional encoder (G1=171, G2=133 octal), DATA_W bits per
// clock, zero-tail terminated: one all-zero word is appended after each burst.
module cc_enc_parm #(
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  cc_enc_parm_if.slave bus
);

  typedef enum logic {DATA, TAIL} state_t;

  state_t              state;
  logic [5:0]          sreg_p1;
  logic [2*DATA_W-1:0] code_p1;
  logic                vld_p1;
  logic                last_p1;
  logic                ready_p1;

  logic [2*DATA_W+5:0] enc_data_p0;
  logic [2*DATA_W+5:0] enc_tail_p0;
  logic                take_p0;

  // Bit-serial encode of one word, unrolled; returns {next_state, coded_word}.
  function automatic logic [2*DATA_W+5:0] enc_word(input logic [5:0] s_in,
                                                   input logic [DATA_W-1:0] d);
    logic [5:0]          s;
    logic [2*DATA_W-1:0] code;
    s    = s_in;
    code = '0;
    for (int k = 0; k < DATA_W; k++) begin
      code[2*k]   = d[k] ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      code[2*k+1] = d[k] ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      s           = {s[4:0], d[k]};
    end
    return {s, code};
  endfunction

  // Stage p0: combinational encode of the incoming word and of the tail word
  assign enc_data_p0 = enc_word(sreg_p1, bus.in_bits);
  assign enc_tail_p0 = enc_word(sreg_p1, '0);
  assign take_p0     = bus.in_valid && ready_p1;

  // Stage p1: registered coded word, state and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DATA;
      sreg_p1  <= '0;
      code_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      ready_p1 <= 1'b1;
    end else if (bus.reload) begin
      state    <= DATA;
      sreg_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      ready_p1 <= 1'b1;
    end else begin
      case (state)
        DATA: begin
          last_p1 <= 1'b0;
          if (take_p0) begin
            sreg_p1 <= enc_data_p0[2*DATA_W +: 6];
            code_p1 <= enc_data_p0[2*DATA_W-1:0];
            vld_p1  <= 1'b1;
            if (bus.in_last) begin
              state    <= TAIL;
              ready_p1 <= 1'b0;
            end
          end else begin
            vld_p1 <= 1'b0;
          end
        end
        TAIL: begin
          sreg_p1  <= enc_tail_p0[2*DATA_W +: 6];
          code_p1  <= enc_tail_p0[2*DATA_W-1:0];
          vld_p1   <= 1'b1;
          last_p1  <= 1'b1;
          state    <= DATA;
          ready_p1 <= 1'b1;
        end
        default: begin
          state    <= DATA;
          vld_p1   <= 1'b0;
          last_p1  <= 1'b0;
          ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_bits  = code_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.in_ready  = ready_p1;

endmodule

// File: tb/tb_cc_enc_parm.sv
// Scoreboard bench for cc_enc_parm: a generator-polynomial reference model
// predicts each coded word; a negedge monitor compares what the encoder emits.
module tb_cc_enc_parm;

  localparam int DATA_W = 8;
  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;

  typedef struct packed {
    logic [2*DATA_W-1:0] bits;
    logic                last;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   hist[$];

  cc_enc_parm_if #(.DATA_W(DATA_W)) bus ();

  cc_enc_parm #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    repeat (6) hist.push_back(1'b0);
  endtask

  // Convolution with the generator taps over the bit history, delay 0 = current bit.
  task automatic model_word(input logic [DATA_W-1:0] d, input logic last, output exp_t e);
    logic [6:0] win;
    logic       x, y;
    e.bits = '0;
    e.last = last;
    for (int k = 0; k < DATA_W; k++) begin
      win[0] = d[k];
      for (int j = 1; j <= 6; j++) win[j] = hist[hist.size() - j];
      x = 1'b0;
      y = 1'b0;
      for (int j = 0; j <= 6; j++) begin
        if (G1[6-j]) x = x ^ win[j];
        if (G2[6-j]) y = y ^ win[j];
      end
      e.bits[2*k]   = x;
      e.bits[2*k+1] = y;
      hist.push_back(d[k]);
      void'(hist.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got word %0h required no output", bus.out_bits);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_bits", 32'(bus.out_bits), 32'(mon_e.bits));
        check("sb_last", 32'(bus.out_last), 32'(mon_e.last));
      end
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      bus.in_bits = DATA_W'($urandom);
      bus.in_last = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic rl,
                      input logic chk, input logic [2*DATA_W-1:0] xd,
                      input logic [2*DATA_W-1:0] xt);
    exp_t e;
    int   waitc;
    waitc        = 0;
    bus.in_bits  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && waitc < 4) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus.in_ready) begin
      check("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    model_word(d, 1'b0, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("data_valid", 32'(bus.out_valid), 32'd1);
    if (chk) begin
      check("data_bits", 32'(bus.out_bits), 32'(xd));
      check("data_last", 32'(bus.out_last), 32'd0);
    end
    if (last) begin
      check("tail_ready_low", 32'(bus.in_ready), 32'd0);
      if (rl) begin
        bus.reload = 1'b1;
        model_clear();
      end else begin
        model_word('0, 1'b1, e);
        exp_q.push_back(e);
        // offer a word the encoder must refuse while the tail is generated
        bus.in_valid = 1'b1;
        bus.in_bits  = DATA_W'($urandom);
        bus.in_last  = 1'($urandom);
      end
      @(posedge clk); #1;
      bus.reload   = 1'b0;
      bus.in_valid = 1'b0;
      if (rl) begin
        check("reload_no_out", 32'(bus.out_valid), 32'd0);
      end else begin
        check("tail_valid", 32'(bus.out_valid), 32'd1);
        check("tail_last", 32'(bus.out_last), 32'd1);
        if (chk) check("tail_bits", 32'(bus.out_bits), 32'(xt));
      end
      check("ready_after_tail", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    int len;
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    bus.in_bits  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.reload   = 1'b0;
    model_clear();
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bits", 32'(bus.out_bits), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    send(8'h01, 1'b1, 1'b0, 1'b1, 16'h38F7, 16'h0000);
    send(8'h80, 1'b1, 1'b0, 1'b1, 16'hC000, 16'h0E3D);
    idle(2);

    for (int b = 0; b < 8; b++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        send(DATA_W'($urandom), (i == len - 1), 1'b0, 1'b0, '0, '0);
        idle(int'($urandom_range(0, 2)));
      end
    end

    send(8'h5A, 1'b0, 1'b0, 1'b0, '0, '0);
    send(8'h01, 1'b1, 1'b1, 1'b0, '0, '0);
    send(8'h01, 1'b1, 1'b0, 1'b1, 16'h38F7, 16'h0000);

    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 3; i++)
        send('0, (i == 2), 1'b0, 1'b1, '0, '0);
    idle(1);

    bus.in_bits  = 8'hC3;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_out_bits", 32'(bus.out_bits), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    check("post_reset_quiet", 32'(bus.out_valid), 32'd0);

    send(8'h01, 1'b1, 1'b0, 1'b1, 16'h38F7, 16'h0000);
    for (int i = 0; i < 5; i++)
      send(DATA_W'($urandom), (i == 4), 1'b0, 1'b0, '0, '0);

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
